seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Iterative, multi-cycle integer divider: quotient and remainder of two WIDTH-bit operands.
- Signed (two's-complement) or unsigned mode, selected per operation.
- One quotient bit per clock (restoring algorithm); start/done handshake.
- Used by datapath blocks that can tolerate fixed multi-cycle latency in place of a combinational divider.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 2.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- a  in  WIDTH  dividend; sampled on the accepting edge.
- b  in  WIDTH  divisor; sampled on the accepting edge.
- sign  in  1  1 = signed operands, 0 = unsigned; sampled with a/b.
- busy  out  1  high from the accepting edge until done is asserted.
- done  out  1  one-cycle pulse; results valid.
- quotient  out  WIDTH  result quotient; held until the next accepted start.
- reminder  out  WIDTH  result remainder (port name is spelled this way); held likewise.
- div_by_zero  out  1  set with done when b was zero; held with results.

Behaviour:
- Reset: state IDLE; busy, done, quotient, reminder and div_by_zero all 0. Reset asserted mid-operation aborts the operation with no done pulse.
- States:
  - IDLE: start=1 on an edge latches a, b and sign, then goes to DIV. Operands are converted to magnitudes when sign=1; result signs are recorded.
  - DIV: exactly WIDTH cycles, one restoring step per cycle, MSB first.
  - FIX: one cycle; applies sign correction and special cases, writes the outputs, then goes to DONE.
  - DONE: one cycle with done=1, then IDLE.
- Latency: start accepted at edge k means done=1 during the cycle after edge k+WIDTH+1, i.e. WIDTH+2 cycles. Latency is fixed for every operand value, including divide-by-zero.
- busy is 1 in the DIV and FIX states and 0 in IDLE and DONE.
- start while busy=1 is ignored (no queueing).
- start during the DONE cycle is accepted, giving back-to-back operation.
- Signed semantics: truncate toward zero.
  - quotient sign = sign(a) XOR sign(b).
  - Remainder sign follows the dividend.
  - Invariant: a == quotient*b + reminder, with |reminder| < |b|.
- Unsigned semantics (sign=0): plain unsigned division.
- Divide by zero (b==0): quotient = all ones, reminder = a, div_by_zero=1. Same in both modes.
- Signed overflow (a = most-negative value, b = -1, sign=1): quotient = a (most-negative value), reminder = 0, div_by_zero=0.
- Magnitude of the most-negative value must be handled as WIDTH-bit unsigned 2^(WIDTH-1).
- Internal partial remainder is WIDTH+1 bits; no other widening is needed.

Decomposition:
- Shared package: state enum (IDLE, DIV, FIX, DONE) and a localparam for the iteration-counter width, $clog2(WIDTH+1).
- Optional sub-module div_step: combinational single restoring step.
  - Inputs: partial remainder, divisor magnitude, next dividend bit.
  - Outputs: new partial remainder and quotient bit.
- Sign handling and FSM stay in seq_divider.

Test Plan:
- Reset then sign=1, a=1, b=1 -> after 10 cycles done pulse, quotient=1, reminder=0; busy low afterwards. Then a=42, b=42 -> quotient=1, reminder=0.
- Signed, a=42, b=7 -> quotient=6, reminder=0. Then a=-42, b=7 -> quotient=-6, reminder=0. Then a=7, b=-42 -> quotient=0, reminder=7.
- Signed, a=10, b=12 -> quotient=0, reminder=10. Then a=127, b=37 -> quotient=3, reminder=16. Then a=-127, b=37 -> quotient=-3, reminder=-16.
- Unsigned, a=8'hFF, b=2 -> quotient=8'h7F, reminder=1. Signed, same operands -> quotient=0, reminder=-1.
- Special cases:
  - a=5, b=0 -> quotient=8'hFF, reminder=5, div_by_zero=1, latency still 10.
  - Signed a=-128, b=-1 -> quotient=-128, reminder=0.
- Handshake:
  - start held while busy -> ignored, no second done.
  - start during the DONE cycle -> accepted back-to-back.
  - rst pulsed mid-DIV -> outputs 0, no done pulse, next start works normally.
- Random: 1000 random signed/unsigned operand pairs checked against the truncation invariant.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package seq_divider_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DIV,
      FIX,
      DONE
   } state_t;

   localparam int unsigned DEFAULT_WIDTH = 8;
   localparam int unsigned CNT_W         = $clog2(DEFAULT_WIDTH + 1);

   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/done request bundle between a datapath client and the divider.
interface seq_divider_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sign;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] reminder;
   logic             div_by_zero;

   modport master (
      output start, a, b, sign,
      input  busy, done, quotient, reminder, div_by_zero
   );

   modport slave (
      input  start, a, b, sign,
      output busy, done, quotient, reminder, div_by_zero
   );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring division step: shift in the next dividend bit, try to subtract.
module seq_divider_div_step #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] divisor,
   input  logic             next_bit,
   output logic [WIDTH:0]   rem_out,
   output logic             q_bit
);
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] trial;

   // rem_in < divisor, so the shifted value fits WIDTH+1 bits and trial's MSB is the borrow
   always_comb begin
      shifted = {rem_in, next_bit};
      trial   = shifted - {2'b00, divisor};
      q_bit   = ~trial[WIDTH+1];
      rem_out = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
   end
endmodule

// File: rtl/seq_divider.sv
// Iterative signed/unsigned integer divider, one quotient bit per clock.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input logic         clk,
   input logic         rst,
   seq_divider_if.slave bus
);
   localparam int unsigned CW = cnt_width(WIDTH);

   state_t           state, next_state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dvd, dvs, a_lat;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   rem, rem_next;
   logic             q_bit, neg_q, neg_r, zero_div, accept;

   seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in   (rem),
      .divisor  (dvs),
      .next_bit (dvd[WIDTH-1]),
      .rem_out  (rem_next),
      .q_bit    (q_bit)
   );

   // -(most negative) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude
   always_comb begin
      a_mag = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      b_mag = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      bus.busy   = 1'b0;
      bus.done   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept     = 1'b1;
               next_state = DIV;
            end
         end
         DIV: begin
            bus.busy = 1'b1;
            if (cnt == CW'(WIDTH - 1)) next_state = FIX;
         end
         FIX: begin
            bus.busy   = 1'b1;
            next_state = DONE;
         end
         DONE: begin
            bus.done = 1'b1;
            if (bus.start) begin
               accept     = 1'b1;
               next_state = DIV;
            end else begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt             <= '0;
         dvd             <= '0;
         dvs             <= '0;
         a_lat           <= '0;
         rem             <= '0;
         neg_q           <= 1'b0;
         neg_r           <= 1'b0;
         zero_div        <= 1'b0;
         bus.quotient    <= '0;
         bus.reminder    <= '0;
         bus.div_by_zero <= 1'b0;
      end else if (accept) begin
         cnt      <= '0;
         dvd      <= a_mag;
         dvs      <= b_mag;
         a_lat    <= bus.a;
         rem      <= '0;
         neg_q    <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
         neg_r    <= bus.sign & bus.a[WIDTH-1];
         zero_div <= (bus.b == '0);
      end else if (state == DIV) begin
         // dividend bits shift out the top while quotient bits shift in the bottom
         dvd <= {dvd[WIDTH-2:0], q_bit};
         rem <= rem_next;
         cnt <= cnt + 1'b1;
      end else if (state == FIX) begin
         if (zero_div) begin
            bus.quotient    <= '1;
            bus.reminder    <= a_lat;
            bus.div_by_zero <= 1'b1;
         end else begin
            bus.quotient    <= neg_q ? -dvd : dvd;
            bus.reminder    <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            bus.div_by_zero <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results queued at issue, checked on done.
module tb_seq_divider;
   localparam int W = 8;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   done_count = 0;
   exp_t sb[$];

   seq_divider_if #(.WIDTH(W)) bus ();

   seq_divider #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      exp_t e;
      int   ia, ib;
      e.acc = 0;
      e.dz  = 1'b0;
      if (b == '0) begin
         e.q  = '1;
         e.r  = a;
         e.dz = 1'b1;
      end else if (!s) begin
         e.q = a / b;
         e.r = a % b;
      end else begin
         ia  = int'($signed(a));
         ib  = int'($signed(b));
         e.q = W'(ia / ib);
         e.r = W'(ia % ib);
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (bus.done) begin
         exp_t e;
         done_count++;
         chk("done_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("quotient", 32'(bus.quotient), 32'(e.q));
            chk("reminder", 32'(bus.reminder), 32'(e.r));
            chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
            chk("latency", 32'(cyc - e.acc), 32'(W + 1));
            chk("busy_at_done", 32'(bus.busy), 32'd0);
         end
      end
   end

   // Called at a falling edge while the DUT can accept; the next rising edge accepts.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      exp_t e;
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.sign  = s;
      e         = model(a, b, s);
      e.acc     = cyc + 1;
      sb.push_back(e);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      @(negedge clk);
      issue(a, b, s);
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_after_accept", 32'(bus.busy), 32'd1);
      wait_drain();
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, n;
      logic [W-1:0] ra, rb;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.sign  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_quotient", 32'(bus.quotient), 32'd0);
      chk("rst_reminder", 32'(bus.reminder), 32'd0);
      chk("rst_dz", 32'(bus.div_by_zero), 32'd0);
      rst = 1'b0;

      launch(8'd1, 8'd1, 1'b1);
      launch(8'd42, 8'd42, 1'b1);
      launch(8'd42, 8'd7, 1'b1);
      launch(-8'sd42, 8'd7, 1'b1);
      launch(8'd7, -8'sd42, 1'b1);
      launch(8'd10, 8'd12, 1'b1);
      launch(8'd127, 8'd37, 1'b1);
      launch(-8'sd127, 8'd37, 1'b1);
      launch(8'hFF, 8'd2, 1'b0);
      launch(8'hFF, 8'd2, 1'b1);
      launch(8'd5, 8'd0, 1'b0);
      launch(8'd5, 8'd0, 1'b1);
      launch(8'h80, 8'hFF, 1'b1);
      launch(8'h80, 8'h01, 1'b1);
      launch(8'hFF, 8'hFF, 1'b0);

      // start held high through part of DIV must not launch another operation
      @(negedge clk);
      issue(8'd100, 8'd9, 1'b0);
      repeat (6) @(negedge clk);
      chk("busy_while_held", 32'(bus.busy), 32'd1);
      bus.start = 1'b0;
      wait_drain();
      d0 = done_count;
      repeat (14) @(negedge clk);
      chk("no_extra_done", 32'(done_count), 32'(d0));

      // back-to-back: second start issued in the DONE cycle
      @(negedge clk);
      issue(8'd200, 8'd3, 1'b0);
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      while (!bus.done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_done_seen", 32'(bus.done), 32'd1);
      issue(-8'sd100, 8'd7, 1'b1);
      @(negedge clk);
      bus.start = 1'b0;
      chk("b2b_accepted", 32'(bus.busy), 32'd1);
      wait_drain();

      // reset mid-DIV aborts without a done pulse
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'd77;
      bus.b     = 8'd5;
      bus.sign  = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_quotient", 32'(bus.quotient), 32'd0);
      chk("abort_reminder", 32'(bus.reminder), 32'd0);
      chk("abort_dz", 32'(bus.div_by_zero), 32'd0);
      d0 = done_count;
      repeat (15) @(negedge clk);
      chk("abort_no_done", 32'(done_count), 32'(d0));
      launch(8'd77, 8'd5, 1'b0);

      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom);
         rb = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
         launch(ra, rb, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
